mem_router: RTL and testbench

Single-outstanding memory request router between the CPU load/store unit and the memory system. Each request is tagged with a cachable flag by the address classifier and routed to one of two ports. Cachable accesses go to the cache port. Uncachable accesses (CSR, UART, VGA/GPIO, QSPI banks) go straight to the Wishbone bypass bus, guarded by a bus timeout. The read data or error is returned to the CPU on a single response channel.

---
 rtl/mem_router.sv | 178 +++++++++++++++++
 tb/tb_mem_router.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_router.sv
// mem_router
//   Single-outstanding request router between the CPU load/store unit and
//   the memory system. A latched request goes either to the cache port
//   (cachable) or to a pipelined Wishbone bypass master (uncachable, guarded
//   by a bus timeout). Completion is reported on a single one-cycle response.
//
// Ports
//   i_clk, i_reset            clock, synchronous active-high reset
//   i_req_*, o_req_ready      CPU request channel (valid/ready)
//   o_rsp_valid/rdata/err     one-cycle response pulse
//   o_c_*, i_c_ready          cache request channel
//   i_c_rsp_valid, i_c_rdata  cache completion
//   o_wb_*, i_wb_*            Wishbone pipelined master
module mem_router #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 255
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic            i_req_valid,
    output logic            o_req_ready,
    input  logic [AW-1:0]   i_req_addr,
    input  logic            i_req_we,
    input  logic [DW-1:0]   i_req_wdata,
    input  logic [DW/8-1:0] i_req_sel,
    input  logic            i_req_cachable,
    output logic            o_rsp_valid,
    output logic [DW-1:0]   o_rsp_rdata,
    output logic            o_rsp_err,
    output logic            o_c_valid,
    output logic            o_c_we,
    output logic [AW-1:0]   o_c_addr,
    output logic [DW-1:0]   o_c_wdata,
    output logic [DW/8-1:0] o_c_sel,
    input  logic            i_c_ready,
    input  logic            i_c_rsp_valid,
    input  logic [DW-1:0]   i_c_rdata,
    output logic            o_wb_cyc,
    output logic            o_wb_stb,
    output logic            o_wb_we,
    output logic [AW-1:0]   o_wb_addr,
    output logic [DW-1:0]   o_wb_data,
    output logic [DW/8-1:0] o_wb_sel,
    input  logic            i_wb_stall,
    input  logic            i_wb_ack,
    input  logic            i_wb_err,
    input  logic [DW-1:0]   i_wb_data
);

    typedef enum logic [2:0] {
        IDLE, CACHE_REQ, CACHE_WAIT, WB_REQ, WB_WAIT, RESP
    } state_t;

    // Abort fires on the edge where the counter holds TIMEOUT-1, i.e. after
    // exactly TIMEOUT cycles spent in WB_REQ/WB_WAIT.
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    state_t            state, state_nxt;
    logic [7:0]        tmo_cnt;
    logic              done;
    logic [DW-1:0]     done_rdata;
    logic              done_err;

    logic [AW-1:0]     req_addr;
    logic              req_we;
    logic [DW-1:0]     req_wdata;
    logic [DW/8-1:0]   req_sel;
    logic              req_cachable;

    // State register
    always_ff @(posedge i_clk) begin
        if (i_reset) state <= IDLE;
        else         state <= state_nxt;
    end

    // Next-state logic; also decides the completion value captured into the
    // response registers on the transition into RESP.
    always_comb begin
        state_nxt  = state;
        done       = 1'b0;
        done_rdata = '0;
        done_err   = 1'b0;
        case (state)
            IDLE: begin
                if (i_req_valid)
                    state_nxt = i_req_cachable ? CACHE_REQ : WB_REQ;
            end
            CACHE_REQ: begin
                if (i_c_ready) begin
                    if (i_c_rsp_valid) begin
                        done       = 1'b1;
                        done_rdata = req_we ? '0 : i_c_rdata;
                        state_nxt  = RESP;
                    end else begin
                        state_nxt = CACHE_WAIT;
                    end
                end
            end
            CACHE_WAIT: begin
                if (i_c_rsp_valid) begin
                    done       = 1'b1;
                    done_rdata = req_we ? '0 : i_c_rdata;
                    state_nxt  = RESP;
                end
            end
            WB_REQ, WB_WAIT: begin
                // A response in WB_REQ only counts once the strobe is taken.
                // err beats ack; any slave response beats the timeout.
                if ((state == WB_WAIT || !i_wb_stall) && (i_wb_ack || i_wb_err)) begin
                    done       = 1'b1;
                    done_err   = i_wb_err;
                    done_rdata = (i_wb_err || req_we) ? '0 : i_wb_data;
                    state_nxt  = RESP;
                end else if (tmo_cnt == TMO_LAST) begin
                    done      = 1'b1;
                    done_err  = 1'b1;
                    state_nxt = RESP;
                end else if (state == WB_REQ && !i_wb_stall) begin
                    state_nxt = WB_WAIT;
                end
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs decoded from registered state only
    always_comb begin
        o_req_ready = (state == IDLE);
        o_c_valid   = (state == CACHE_REQ) && req_cachable;
        o_wb_cyc    = (state == WB_REQ) || (state == WB_WAIT);
        o_wb_stb    = (state == WB_REQ);
        o_rsp_valid = (state == RESP);
    end

    // Bypass timeout counter: cleared on entry to WB_REQ
    always_ff @(posedge i_clk) begin
        if (i_reset)
            tmo_cnt <= '0;
        else if (state == IDLE && i_req_valid && !i_req_cachable)
            tmo_cnt <= '0;
        else if (state == WB_REQ || state == WB_WAIT)
            tmo_cnt <= tmo_cnt + 8'd1;
    end

    // Request register: the only source for both downstream ports
    always_ff @(posedge i_clk) begin
        if (state == IDLE && i_req_valid) begin
            req_addr     <= i_req_addr;
            req_we       <= i_req_we;
            req_wdata    <= i_req_wdata;
            req_sel      <= i_req_sel;
            req_cachable <= i_req_cachable;
        end
    end

    // Response registers
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_rsp_rdata <= '0;
            o_rsp_err   <= 1'b0;
        end else if (done) begin
            o_rsp_rdata <= done_rdata;
            o_rsp_err   <= done_err;
        end
    end

    assign o_c_we    = req_we;
    assign o_c_addr  = req_addr;
    assign o_c_wdata = req_wdata;
    assign o_c_sel   = req_sel;
    assign o_wb_we   = req_we;
    assign o_wb_addr = req_addr;
    assign o_wb_data = req_wdata;
    assign o_wb_sel  = req_sel;

endmodule

// File: tb/tb_mem_router.sv
module tb_mem_router;

    logic        i_clk = 1'b0;
    logic        i_reset;
    logic        i_req_valid;
    logic        o_req_ready;
    logic [31:0] i_req_addr;
    logic        i_req_we;
    logic [31:0] i_req_wdata;
    logic [3:0]  i_req_sel;
    logic        i_req_cachable;
    logic        o_rsp_valid;
    logic [31:0] o_rsp_rdata;
    logic        o_rsp_err;
    logic        o_c_valid;
    logic        o_c_we;
    logic [31:0] o_c_addr;
    logic [31:0] o_c_wdata;
    logic [3:0]  o_c_sel;
    logic        i_c_ready;
    logic        i_c_rsp_valid;
    logic [31:0] i_c_rdata;
    logic        o_wb_cyc;
    logic        o_wb_stb;
    logic        o_wb_we;
    logic [31:0] o_wb_addr;
    logic [31:0] o_wb_data;
    logic [3:0]  o_wb_sel;
    logic        i_wb_stall;
    logic        i_wb_ack;
    logic        i_wb_err;
    logic [31:0] i_wb_data;

    int vectors = 0;
    int miscompares = 0;

    mem_router #(.AW(32), .DW(32), .TIMEOUT(8)) dut (
        .i_clk(i_clk), .i_reset(i_reset),
        .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
        .i_req_addr(i_req_addr), .i_req_we(i_req_we),
        .i_req_wdata(i_req_wdata), .i_req_sel(i_req_sel),
        .i_req_cachable(i_req_cachable),
        .o_rsp_valid(o_rsp_valid), .o_rsp_rdata(o_rsp_rdata), .o_rsp_err(o_rsp_err),
        .o_c_valid(o_c_valid), .o_c_we(o_c_we), .o_c_addr(o_c_addr),
        .o_c_wdata(o_c_wdata), .o_c_sel(o_c_sel), .i_c_ready(i_c_ready),
        .i_c_rsp_valid(i_c_rsp_valid), .i_c_rdata(i_c_rdata),
        .o_wb_cyc(o_wb_cyc), .o_wb_stb(o_wb_stb), .o_wb_we(o_wb_we),
        .o_wb_addr(o_wb_addr), .o_wb_data(o_wb_data), .o_wb_sel(o_wb_sel),
        .i_wb_stall(i_wb_stall), .i_wb_ack(i_wb_ack), .i_wb_err(i_wb_err),
        .i_wb_data(i_wb_data)
    );

    always #5 i_clk = ~i_clk;

    // Advance one rising edge; outputs are sampled 1 ns after it.
    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic drive_req(input logic [31:0] addr, input logic we,
                             input logic [31:0] wdata, input logic [3:0] sel,
                             input logic cach);
        i_req_valid    = 1'b1;
        i_req_addr     = addr;
        i_req_we       = we;
        i_req_wdata    = wdata;
        i_req_sel      = sel;
        i_req_cachable = cach;
    endtask

    task automatic test_reset();
        i_reset = 1'b1;
        i_req_valid = 0; i_req_addr = 0; i_req_we = 0; i_req_wdata = 0;
        i_req_sel = 0; i_req_cachable = 0;
        i_c_ready = 0; i_c_rsp_valid = 0; i_c_rdata = 0;
        i_wb_stall = 0; i_wb_ack = 0; i_wb_err = 0; i_wb_data = 0;
        step(); step();
        i_reset = 1'b0;
        step();
        vectors++;
        if ({o_req_ready, o_rsp_valid, o_rsp_err, o_c_valid, o_wb_cyc, o_wb_stb} !== 6'b100000) begin
            miscompares++;
            $display("FAIL reset_ctrl got %b want 100000",
                     {o_req_ready, o_rsp_valid, o_rsp_err, o_c_valid, o_wb_cyc, o_wb_stb});
        end
        vectors++;
        if (o_rsp_rdata !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_rdata got %h want 00000000", o_rsp_rdata);
        end
    endtask

    task automatic test_uncached_read();
        drive_req(32'h28000010, 1'b0, 32'h0, 4'hF, 1'b0);
        i_wb_stall = 0;
        vectors++;
        if (o_req_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL ucr_ready got %b want 1", o_req_ready);
        end
        step();                                 // accept
        i_req_valid = 0;
        i_wb_ack = 1; i_wb_data = 32'hDEADBEEF;  // zero-wait slave
        vectors++;
        if ({o_wb_cyc, o_wb_stb, o_c_valid, o_rsp_valid} !== 4'b1100) begin
            miscompares++;
            $display("FAIL ucr_stb got %b want 1100", {o_wb_cyc, o_wb_stb, o_c_valid, o_rsp_valid});
        end
        vectors++;
        if ({o_wb_addr, o_wb_we} !== {32'h28000010, 1'b0}) begin
            miscompares++;
            $display("FAIL ucr_addr got %h/%b want 28000010/0", o_wb_addr, o_wb_we);
        end
        step();
        i_wb_ack = 0;
        vectors++;
        if ({o_wb_cyc, o_wb_stb, o_c_valid, o_rsp_valid, o_rsp_err} !== 5'b00010) begin
            miscompares++;
            $display("FAIL ucr_rsp got %b want 00010",
                     {o_wb_cyc, o_wb_stb, o_c_valid, o_rsp_valid, o_rsp_err});
        end
        vectors++;
        if (o_rsp_rdata !== 32'hDEADBEEF) begin
            miscompares++;
            $display("FAIL ucr_rdata got %h want deadbeef", o_rsp_rdata);
        end
        step();
        vectors++;
        if ({o_rsp_valid, o_req_ready, o_wb_stb} !== 3'b010) begin
            miscompares++;
            $display("FAIL ucr_idle got %b want 010", {o_rsp_valid, o_req_ready, o_wb_stb});
        end
    endtask

    task automatic test_cached_write();
        drive_req(32'h00001000, 1'b1, 32'h12345678, 4'hF, 1'b1);
        step();                                 // accept
        i_req_valid = 0;
        i_req_wdata = 32'hFFFFFFFF;             // live input must not reach the port
        vectors++;
        if ({o_c_valid, o_c_we, o_c_addr, o_c_wdata, o_c_sel} !== {2'b11, 32'h00001000, 32'h12345678, 4'hF}) begin
            miscompares++;
            $display("FAIL cw_req got %b%b %h %h %h want 11 00001000 12345678 f",
                     o_c_valid, o_c_we, o_c_addr, o_c_wdata, o_c_sel);
        end
        step();                                 // ready still low
        i_c_ready = 1;
        vectors++;
        if (o_c_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL cw_hold got %b want 1", o_c_valid);
        end
        step();                                 // cache takes request
        i_c_ready = 0;
        for (int i = 0; i < 2; i++) begin
            vectors++;
            if ({o_c_valid, o_rsp_valid, o_wb_cyc, o_wb_stb} !== 4'b0000) begin
                miscompares++;
                $display("FAIL cw_wait%0d got %b want 0000", i, {o_c_valid, o_rsp_valid, o_wb_cyc, o_wb_stb});
            end
            step();
        end
        vectors++;
        if (o_rsp_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL cw_wait2 got %b want 0", o_rsp_valid);
        end
        i_c_rsp_valid = 1; i_c_rdata = 32'hAAAA5555;
        step();
        i_c_rsp_valid = 0;
        vectors++;
        if ({o_rsp_valid, o_rsp_err, o_rsp_rdata, o_wb_cyc} !== {2'b10, 32'h0, 1'b0}) begin
            miscompares++;
            $display("FAIL cw_rsp got %b%b %h cyc=%b want 10 00000000 cyc=0",
                     o_rsp_valid, o_rsp_err, o_rsp_rdata, o_wb_cyc);
        end
        step();
        vectors++;
        if ({o_rsp_valid, o_req_ready} !== 2'b01) begin
            miscompares++;
            $display("FAIL cw_once got %b want 01", {o_rsp_valid, o_req_ready});
        end
    endtask

    task automatic test_stall();
        drive_req(32'h20000004, 1'b1, 32'hCAFEF00D, 4'h3, 1'b0);
        i_wb_stall = 1;
        step();                                 // accept
        i_req_valid = 0;
        i_req_addr = 32'h0; i_req_wdata = 32'h0;
        for (int i = 0; i < 5; i++) begin
            if (i == 4) i_wb_stall = 0;
            vectors++;
            if ({o_wb_cyc, o_wb_stb, o_wb_addr, o_wb_data, o_wb_sel, o_rsp_valid}
                    !== {2'b11, 32'h20000004, 32'hCAFEF00D, 4'h3, 1'b0}) begin
                miscompares++;
                $display("FAIL stall_stb%0d got %b%b %h %h %h rv=%b want 11 20000004 cafef00d 3 rv=0",
                         i, o_wb_cyc, o_wb_stb, o_wb_addr, o_wb_data, o_wb_sel, o_rsp_valid);
            end
            step();
        end
        vectors++;
        if ({o_wb_cyc, o_wb_stb} !== 2'b10) begin
            miscompares++;
            $display("FAIL stall_wait got %b want 10", {o_wb_cyc, o_wb_stb});
        end
        step();
        i_wb_ack = 1;
        step();
        i_wb_ack = 0;
        vectors++;
        if ({o_rsp_valid, o_rsp_err, o_rsp_rdata, o_wb_cyc} !== {2'b10, 32'h0, 1'b0}) begin
            miscompares++;
            $display("FAIL stall_rsp got %b%b %h cyc=%b want 10 00000000 cyc=0",
                     o_rsp_valid, o_rsp_err, o_rsp_rdata, o_wb_cyc);
        end
        step();
        vectors++;
        if (o_rsp_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL stall_once got %b want 0", o_rsp_valid);
        end
    endtask

    task automatic test_timeout();
        drive_req(32'h30000000, 1'b0, 32'h0, 4'hF, 1'b0);
        i_wb_stall = 0;
        step();                                 // accept: WB_REQ entered here
        i_req_valid = 0;
        for (int i = 1; i < 8; i++) begin
            vectors++;
            if ({o_wb_cyc, o_rsp_valid} !== 2'b10) begin
                miscompares++;
                $display("FAIL tmo_cyc%0d got %b want 10", i, {o_wb_cyc, o_rsp_valid});
            end
            step();
        end
        vectors++;
        if ({o_wb_cyc, o_rsp_valid} !== 2'b10) begin
            miscompares++;
            $display("FAIL tmo_cyc8 got %b want 10", {o_wb_cyc, o_rsp_valid});
        end
        step();                                 // 8 cycles after entry
        i_wb_ack = 1; i_wb_data = 32'h11111111; // late ack
        vectors++;
        if ({o_wb_cyc, o_rsp_valid, o_rsp_err, o_rsp_rdata} !== {3'b011, 32'h0}) begin
            miscompares++;
            $display("FAIL tmo_abort got %b%b%b %h want 011 00000000",
                     o_wb_cyc, o_rsp_valid, o_rsp_err, o_rsp_rdata);
        end
        step();
        step();
        i_wb_ack = 0;
        vectors++;
        if ({o_rsp_valid, o_req_ready, o_wb_cyc, o_rsp_rdata} !== {3'b010, 32'h0}) begin
            miscompares++;
            $display("FAIL tmo_late got %b%b%b %h want 010 00000000",
                     o_rsp_valid, o_req_ready, o_wb_cyc, o_rsp_rdata);
        end
    endtask

    task automatic test_ack_err();
        drive_req(32'h28000020, 1'b0, 32'h0, 4'hF, 1'b0);
        step();
        i_req_valid = 0;
        i_wb_ack = 1; i_wb_err = 1; i_wb_data = 32'hFFFFFFFF;
        step();
        i_wb_ack = 0; i_wb_err = 0;
        vectors++;
        if ({o_rsp_valid, o_rsp_err, o_rsp_rdata} !== {2'b11, 32'h0}) begin
            miscompares++;
            $display("FAIL ackerr got %b%b %h want 11 00000000", o_rsp_valid, o_rsp_err, o_rsp_rdata);
        end
        step();
    endtask

    task automatic test_reset_mid();
        drive_req(32'h28000030, 1'b0, 32'h0, 4'hF, 1'b0);
        step();                                 // WB_REQ
        i_req_valid = 0;
        step();                                 // WB_WAIT
        vectors++;
        if ({o_wb_cyc, o_wb_stb} !== 2'b10) begin
            miscompares++;
            $display("FAIL rst_wait got %b want 10", {o_wb_cyc, o_wb_stb});
        end
        i_reset = 1;
        step();
        i_reset = 0;
        vectors++;
        if ({o_wb_cyc, o_wb_stb, o_rsp_valid, o_req_ready} !== 4'b0001) begin
            miscompares++;
            $display("FAIL rst_abort got %b want 0001", {o_wb_cyc, o_wb_stb, o_rsp_valid, o_req_ready});
        end
        step();
        vectors++;
        if ({o_rsp_valid, o_req_ready} !== 2'b01) begin
            miscompares++;
            $display("FAIL rst_norsp got %b want 01", {o_rsp_valid, o_req_ready});
        end
        drive_req(32'h00000040, 1'b0, 32'h0, 4'hF, 1'b1);
        step();                                 // accept
        i_req_valid = 0;
        i_c_ready = 1; i_c_rsp_valid = 1; i_c_rdata = 32'h0BADCAFE;
        vectors++;
        if ({o_c_valid, o_c_addr} !== {1'b1, 32'h00000040}) begin
            miscompares++;
            $display("FAIL rst_creq got %b %h want 1 00000040", o_c_valid, o_c_addr);
        end
        step();
        i_c_ready = 0; i_c_rsp_valid = 0;
        vectors++;
        if ({o_rsp_valid, o_rsp_err, o_rsp_rdata, o_c_valid} !== {2'b10, 32'h0BADCAFE, 1'b0}) begin
            miscompares++;
            $display("FAIL rst_crsp got %b%b %h cv=%b want 10 0badcafe cv=0",
                     o_rsp_valid, o_rsp_err, o_rsp_rdata, o_c_valid);
        end
        step();
    endtask

    initial begin
        test_reset();
        test_uncached_read();
        test_cached_write();
        test_stall();
        test_timeout();
        test_ack_err();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
